reg_write_buffer: RTL and testbench

Write-back staging buffer sitting directly upstream of the 32 x 32-bit register bank. It accepts register-write requests (addr, data) over a valid/ready handshake and queues them in a small FIFO. It drains one write per cycle into the bank by driving the shared data_in bus, the common WE line and the one-hot per-register selector lines. It also provides a forwarding lookup so readers see pending writes before they land.

---
 rtl/reg_write_buffer_pkg.sv | 30 +++
 rtl/reg_write_buffer_if.sv | 47 ++++
 rtl/reg_write_buffer_wb_fifo.sv | 77 +++++++
 rtl/reg_write_buffer.sv | 120 ++++++++++++
 tb/tb_reg_write_buffer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_buffer_pkg
// Purpose  : Shared constants, the write-request record and the
//            address-to-one-hot decode used by the register write path.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package reg_write_buffer_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 2 ** ADDR_W;
  localparam int REQ_W  = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_req_t;

  // One-hot register selector for a given address; shared with read muxing.
  function automatic logic [NREGS-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
    logic [NREGS-1:0] v_sel;
    v_sel       = '0;
    v_sel[addr] = 1'b1;
    return v_sel;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_buffer_if.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_buffer_if
// Purpose  : Bundles the request handshake, bank-write bus, forwarding
//            lookup and status signals of the register write buffer.
// Ports    : none (interface). Modport slave = the buffer, master = the
//            surrounding pipeline / bank side that drives requests.
//            in_valid/in_ready/in_addr/in_data : request handshake
//            hold                              : stall draining
//            wr_en/wr_sel/wr_data              : register bank write bus
//            fwd_addr/fwd_hit/fwd_data         : forwarding lookup
//            count/empty                       : status
// Revision : 1.0  initial release
// ============================================================================
interface reg_write_buffer_if #(
  parameter int DEPTH = 4
);
  import reg_write_buffer_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_addr;
  logic [DATA_W-1:0] in_data;
  logic              hold;
  logic              wr_en;
  logic [NREGS-1:0]  wr_sel;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] fwd_addr;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
  logic [CNT_W-1:0]  count;
  logic              empty;

  modport slave (
    input  in_valid, in_addr, in_data, hold, fwd_addr,
    output in_ready, wr_en, wr_sel, wr_data, fwd_hit, fwd_data, count, empty
  );

  modport master (
    output in_valid, in_addr, in_data, hold, fwd_addr,
    input  in_ready, wr_en, wr_sel, wr_data, fwd_hit, fwd_data, count, empty
  );

endinterface
`default_nettype wire

// File: rtl/reg_write_buffer_wb_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_fifo
// Purpose  : Generic circular FIFO with occupancy count. All entries are
//            exported in age order (index 0 = head/oldest) together with a
//            valid mask so the caller can search pending data.
// Ports    : clk, reset      : clock, async active-high reset
//            i_push/i_data   : enqueue (ignored when full)
//            i_pop           : dequeue (ignored when empty)
//            o_head          : oldest entry
//            o_count         : occupancy
//            o_entries/o_valid : age-ordered contents and valid mask
// Revision : 1.0  initial release
// ============================================================================
module wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 37
) (
  input  wire logic                          clk,
  input  wire logic                          reset,
  input  wire logic                          i_push,
  input  wire logic [WIDTH-1:0]              i_data,
  input  wire logic                          i_pop,
  output logic      [WIDTH-1:0]              o_head,
  output logic      [$clog2(DEPTH):0]        o_count,
  output logic      [DEPTH-1:0][WIDTH-1:0]   o_entries,
  output logic      [DEPTH-1:0]              o_valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign w_push = i_push && (r_count != CNT_W'(DEPTH));
  assign w_pop  = i_pop  && (r_count != '0);

  // DEPTH is a power of two, so pointer overflow is the modulo wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset: only entries covered by o_valid are meaningful.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] w_idx;
    assign w_idx        = r_rd_ptr + PTR_W'(k);
    assign o_entries[k] = r_mem[w_idx];
    assign o_valid[k]   = (CNT_W'(k) < r_count);
  end

endmodule
`default_nettype wire

// File: rtl/reg_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_buffer
// Purpose  : Write-back staging buffer in front of the 32 x 32-bit register
//            bank. Queues (addr, data) requests, drains one per cycle into
//            the bank through a one-cycle output stage, and forwards the
//            youngest pending write to readers.
// Ports    : clk   : rising-edge clock shared with the bank
//            reset : asynchronous active-high reset
//            bus   : reg_write_buffer_if.slave (handshake, bank bus,
//                    forwarding lookup, count/empty status)
// Revision : 1.0  initial release
// ============================================================================
module reg_write_buffer
  import reg_write_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire logic           clk,
  input  wire logic           reset,
  reg_write_buffer_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [CNT_W-1:0]            w_count;
  logic [REQ_W-1:0]            w_head_raw;
  logic [DEPTH-1:0][REQ_W-1:0] w_entries;
  logic [DEPTH-1:0]            w_valid;
  wr_req_t                     w_head;
  wr_req_t                     w_in_req;
  wr_req_t                     w_ent;
  logic                        w_in_ready;
  logic                        w_push;
  logic                        w_pop;
  logic                        w_fwd_hit;
  logic [DATA_W-1:0]           w_fwd_data;

  logic                        r_wr_en;
  logic [NREGS-1:0]            r_wr_sel;
  logic [DATA_W-1:0]           r_wr_data;
  logic [ADDR_W-1:0]           r_out_addr;

  // Readiness comes from the registered count only; a pop on the same edge
  // does not open a slot for the incoming request.
  assign w_in_ready = (w_count < CNT_W'(DEPTH));

  // Address 0 completes the handshake but is dropped: it never reaches the bank.
  assign w_push   = bus.in_valid && w_in_ready && (bus.in_addr != '0);
  assign w_pop    = !bus.hold && (w_count != '0);
  assign w_in_req = '{addr: bus.in_addr, data: bus.in_data};
  assign w_head   = w_head_raw;

  wb_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .i_push    (w_push),
    .i_data    (w_in_req),
    .i_pop     (w_pop),
    .o_head    (w_head_raw),
    .o_count   (w_count),
    .o_entries (w_entries),
    .o_valid   (w_valid)
  );

  // Output stage: a popped entry drives the bank for exactly one cycle.
  // wr_data holds its last value when idle; only wr_en/wr_sel return to 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_en    <= 1'b0;
      r_wr_sel   <= '0;
      r_wr_data  <= '0;
      r_out_addr <= '0;
    end else begin
      r_wr_en <= w_pop;
      if (w_pop) begin
        r_wr_sel   <= addr_to_onehot(w_head.addr);
        r_wr_data  <= w_head.data;
        r_out_addr <= w_head.addr;
      end else begin
        r_wr_sel   <= '0;
      end
    end
  end

  // Forwarding: scan oldest to youngest so a later match overrides an
  // earlier one; the output stage is older than anything still queued.
  always_comb begin
    w_fwd_hit  = 1'b0;
    w_fwd_data = '0;
    w_ent      = '0;
    if (bus.fwd_addr != '0) begin
      if (r_wr_en && (r_out_addr == bus.fwd_addr)) begin
        w_fwd_hit  = 1'b1;
        w_fwd_data = r_wr_data;
      end
      for (int k = 0; k < DEPTH; k++) begin
        w_ent = w_entries[k];
        if (w_valid[k] && (w_ent.addr == bus.fwd_addr)) begin
          w_fwd_hit  = 1'b1;
          w_fwd_data = w_ent.data;
        end
      end
    end
  end

  assign bus.in_ready = w_in_ready;
  assign bus.wr_en    = r_wr_en;
  assign bus.wr_sel   = r_wr_sel;
  assign bus.wr_data  = r_wr_data;
  assign bus.fwd_hit  = w_fwd_hit;
  assign bus.fwd_data = w_fwd_data;
  assign bus.count    = w_count;
  assign bus.empty    = (w_count == '0) && !r_wr_en;

endmodule
`default_nettype wire

// File: tb/tb_reg_write_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_buffer
// Purpose  : Directed self-checking bench for reg_write_buffer with a
//            behavioural register bank attached to the write bus.
// Ports    : none
// Revision : 1.0  initial release
// ============================================================================
module tb_reg_write_buffer;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_pass;
  int   n_fail;
  logic mon_en;
  logic [31:0] bank [32];

  reg_write_buffer_if #(.DEPTH(4)) bus ();

  reg_write_buffer #(.DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank: every register sees WE/data_in, only the selected one loads.
  always @(posedge clk) begin
    if (bus.wr_en === 1'b1) begin
      for (int i = 0; i < 32; i++) begin
        if (bus.wr_sel[i]) bank[i] <= bus.wr_data;
      end
    end
  end

  // Continuous structural checks: selector never multi-hot, count bounded.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      n_checks++;
      assert ($onehot0(bus.wr_sel) && (bus.count <= 3'd4)) n_pass++;
      else begin
        n_fail++;
        $error("FAIL monitor: wr_sel=%h count=%0d required onehot0 and count<=4",
               bus.wr_sel, bus.count);
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0]  wa [10];
    int          k;
    int          guard;
    int          g;
    logic        acc;

    n_checks = 0; n_pass = 0; n_fail = 0; mon_en = 1'b0;
    for (int i = 0; i < 32; i++) bank[i] = '0;
    reset = 1'b0;
    bus.in_valid = 1'b0; bus.in_addr = '0; bus.in_data = '0;
    bus.hold = 1'b0; bus.fwd_addr = '0;
    wa = '{5'd10, 5'd11, 5'd10, 5'd12, 5'd13, 5'd11, 5'd14, 5'd10, 5'd15, 5'd12};

    // ---------------- reset state
    #1 reset = 1'b1;
    #1;
    check("rst_wr_en",    bus.wr_en,    1'b0);
    check("rst_wr_sel",   bus.wr_sel,   32'h0);
    check("rst_wr_data",  bus.wr_data,  32'h0);
    check("rst_count",    bus.count,    3'd0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    check("rst_empty",    bus.empty,    1'b1);
    check("rst_fwd_hit",  bus.fwd_hit,  1'b0);
    tick(); tick();
    reset = 1'b0;
    mon_en = 1'b1;

    // ---------------- single write: r5 <= DEADBEEF
    bus.in_valid = 1'b1; bus.in_addr = 5'd5; bus.in_data = 32'hDEADBEEF;
    bus.fwd_addr = 5'd5;
    tick();                                   // edge 0: accepted
    bus.in_valid = 1'b0;
    check("sw_count_e0",  bus.count,    3'd1);
    check("sw_wr_en_e0",  bus.wr_en,    1'b0);
    check("sw_fwd_hit",   bus.fwd_hit,  1'b1);
    check("sw_fwd_data",  bus.fwd_data, 32'hDEADBEEF);
    tick();                                   // edge 1: output stage
    check("sw_wr_en_e1",  bus.wr_en,    1'b1);
    check("sw_wr_sel_e1", bus.wr_sel,   32'h0000_0020);
    check("sw_wr_data",   bus.wr_data,  32'hDEADBEEF);
    check("sw_count_e1",  bus.count,    3'd0);
    tick();                                   // edge 2: bank captures
    check("sw_wr_en_e2",  bus.wr_en,    1'b0);
    check("sw_wr_sel_e2", bus.wr_sel,   32'h0);
    check("sw_data_kept", bus.wr_data,  32'hDEADBEEF);
    check("sw_bank5",     bank[5],      32'hDEADBEEF);
    check("sw_empty",     bus.empty,    1'b1);

    // ---------------- reset mid-drain
    bus.hold = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'(i * 11);
      tick();
    end
    bus.in_valid = 1'b0; bus.hold = 1'b0;
    check("rmd_count3",   bus.count,    3'd3);
    tick();
    check("rmd_wr_en_pre", bus.wr_en,   1'b1);
    check("rmd_sel_pre",   bus.wr_sel,  32'h2);
    #1 reset = 1'b1;
    #1;
    check("rmd_wr_en",    bus.wr_en,    1'b0);
    check("rmd_wr_sel",   bus.wr_sel,   32'h0);
    check("rmd_count",    bus.count,    3'd0);
    check("rmd_in_ready", bus.in_ready, 1'b1);
    check("rmd_empty",    bus.empty,    1'b1);
    #1 reset = 1'b0;
    tick(); tick(); tick(); tick();
    check("rmd_bank1",    bank[1],      32'h0);
    check("rmd_bank2",    bank[2],      32'h0);
    check("rmd_bank3",    bank[3],      32'h0);
    check("rmd_wr_en_after", bus.wr_en, 1'b0);

    // ---------------- full / backpressure
    bus.hold = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus.in_valid = 1'b1; bus.in_addr = 5'(i); bus.in_data = 32'h100 + 32'(i);
      tick();
    end
    bus.in_addr = 5'd6; bus.in_data = 32'h666;
    check("full_count",    bus.count,    3'd4);
    check("full_in_ready", bus.in_ready, 1'b0);
    tick();
    check("full_count_5th", bus.count,   3'd4);
    bus.in_valid = 1'b0; bus.hold = 1'b0;
    tick();
    check("bp_wr_en1",    bus.wr_en,    1'b1);
    check("bp_sel1",      bus.wr_sel,   32'h2);
    check("bp_data1",     bus.wr_data,  32'h101);
    check("bp_count3",    bus.count,    3'd3);
    check("bp_ready_back", bus.in_ready, 1'b1);
    tick();
    check("bp_sel2",      bus.wr_sel,   32'h4);
    check("bp_data2",     bus.wr_data,  32'h102);
    tick();
    check("bp_sel3",      bus.wr_sel,   32'h8);
    check("bp_data3",     bus.wr_data,  32'h103);
    tick();
    check("bp_sel4",      bus.wr_sel,   32'h10);
    check("bp_data4",     bus.wr_data,  32'h104);
    check("bp_count0",    bus.count,    3'd0);
    tick();
    check("bp_idle",      bus.wr_en,    1'b0);
    check("bp_empty",     bus.empty,    1'b1);
    check("bp_bank1",     bank[1],      32'h101);
    check("bp_bank4",     bank[4],      32'h104);
    check("bp_bank6",     bank[6],      32'h0);

    // ---------------- address 0 is dropped
    bus.fwd_addr = 5'd0;
    bus.in_valid = 1'b1; bus.in_addr = 5'd0; bus.in_data = 32'h1234;
    check("a0_in_ready",  bus.in_ready, 1'b1);
    tick();
    check("a0_count",     bus.count,    3'd0);
    check("a0_empty",     bus.empty,    1'b1);
    bus.in_addr = 5'd7; bus.in_data = 32'h55;
    tick();
    bus.in_valid = 1'b0;
    check("a0_count1",    bus.count,    3'd1);
    check("a0_fwd0_q",    bus.fwd_hit,  1'b0);
    tick();
    check("a0_wr_en",     bus.wr_en,    1'b1);
    check("a0_sel",       bus.wr_sel,   32'h80);
    check("a0_data",      bus.wr_data,  32'h55);
    check("a0_fwd0_out",  bus.fwd_hit,  1'b0);
    tick();
    check("a0_no_pulse",  bus.wr_en,    1'b0);
    check("a0_bank0",     bank[0],      32'h0);
    check("a0_bank7",     bank[7],      32'h55);

    // ---------------- forwarding priority
    bus.hold = 1'b1;
    bus.in_valid = 1'b1; bus.in_addr = 5'd9; bus.in_data = 32'hA; tick();
    bus.in_addr = 5'd9; bus.in_data = 32'hB; tick();
    bus.in_addr = 5'd3; bus.in_data = 32'hC; tick();
    bus.in_valid = 1'b0;
    bus.fwd_addr = 5'd9; #1;
    check("fw9_hit",      bus.fwd_hit,  1'b1);
    check("fw9_data",     bus.fwd_data, 32'hB);
    bus.fwd_addr = 5'd4; #1;
    check("fw4_hit",      bus.fwd_hit,  1'b0);
    check("fw4_data",     bus.fwd_data, 32'h0);
    bus.fwd_addr = 5'd3; #1;
    check("fw3_data",     bus.fwd_data, 32'hC);
    bus.fwd_addr = 5'd9;
    bus.hold = 1'b0;
    tick();                                   // A in output stage
    check("fwA_out_data", bus.fwd_data, 32'hB);
    tick();                                   // B in output stage
    check("fwB_out_sel",  bus.wr_data,  32'hB);
    check("fwB_out_hit",  bus.fwd_hit,  1'b1);
    check("fwB_out_data", bus.fwd_data, 32'hB);
    tick();                                   // C in output stage
    check("fw_gone_hit",  bus.fwd_hit,  1'b0);
    check("fw_gone_data", bus.fwd_data, 32'h0);
    tick();
    check("fw_bank9",     bank[9],      32'hB);
    check("fw_bank3",     bank[3],      32'hC);

    // ---------------- wrap-around stream with toggling hold
    k = 0;
    guard = 0;
    while (k < 10 && guard < 100) begin
      bus.in_valid = 1'b1;
      bus.in_addr  = wa[k];
      bus.in_data  = 32'h1000 + 32'(k);
      bus.hold     = (guard % 2) == 1;
      acc = bus.in_ready;
      tick();
      if (acc) k++;
      guard++;
    end
    bus.in_valid = 1'b0;
    bus.hold     = 1'b0;
    check("wrap_accepted", 64'(k), 64'd10);
    g = 0;
    while (bus.empty !== 1'b1 && g < 20) begin
      tick();
      g++;
    end
    check("wrap_drained", bus.empty, 1'b1);
    check("wrap_bank10",  bank[10], 32'h1007);
    check("wrap_bank11",  bank[11], 32'h1005);
    check("wrap_bank12",  bank[12], 32'h1009);
    check("wrap_bank13",  bank[13], 32'h1004);
    check("wrap_bank14",  bank[14], 32'h1006);
    check("wrap_bank15",  bank[15], 32'h1008);

    mon_en = 1'b0;
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
